// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the sequential population counter.
// Holds the FSM encodings, a constant clog2 and the parameter guard macro.
package cnt_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_COUNT = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

`ifndef CNT_ELAB_CHECK
`define CNT_ELAB_CHECK(DW, BPC, CW) \
  if ((BPC) < 1 || (BPC) > (DW) || ((DW) % (BPC)) != 0 || \
      (CW) < cnt_pkg::clog2((DW) + 1)) begin : g_bad_cfg \
    $error("count_ones_seq: illegal parameter set"); \
  end
`endif

// File: rtl/popcount_slice.sv
// Combinational ones-count of one W-bit slice.
// Result width is just wide enough to hold W.
module popcount_slice
  import cnt_pkg::*;
#(
  parameter int W = 4,
  localparam int PW = clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [PW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + PW'(bits[i]);
    end
  end

endmodule

// File: rtl/count_ones_seq.sv
// Sequential population counter: consumes BITS_PER_CYCLE bits per clock.
// Counts ones, or zeros via an inverted load, with optional early exit.
module count_ones_seq
  import cnt_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int BITS_PER_CYCLE = 4,
  parameter int COUNT_WIDTH    = 5,
  parameter int EARLY_EXIT     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic                   mode,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] bit_count
);

  localparam int N  = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int SW = (clog2(N) < 1) ? 1 : clog2(N);
  localparam int PW = clog2(BITS_PER_CYCLE + 1);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  `CNT_ELAB_CHECK(DATA_WIDTH, BITS_PER_CYCLE, COUNT_WIDTH)

  logic                   state;
  logic [DATA_WIDTH-1:0]  shift;
  logic [DATA_WIDTH-1:0]  shift_nxt;
  logic [COUNT_WIDTH-1:0] acc;
  logic [COUNT_WIDTH-1:0] sum;
  logic [SW-1:0]          slice;
  logic [PW-1:0]          pc;
  logic                   finish;

  popcount_slice #(
    .W (BITS_PER_CYCLE)
  ) u_pc (
    .bits (shift[BITS_PER_CYCLE-1:0]),
    .cnt  (pc)
  );

  assign sum       = acc + COUNT_WIDTH'(pc);
  assign shift_nxt = shift >> BITS_PER_CYCLE;
  assign finish    = (slice == LAST) ||
                     ((EARLY_EXIT != 0) && (shift_nxt == '0));
  assign busy      = (state == ST_COUNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      shift     <= '0;
      acc       <= '0;
      slice     <= '0;
      done      <= 1'b0;
      bit_count <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // zeros mode just counts ones of the inverted word
          if (start) begin
            shift <= mode ? ~data : data;
            acc   <= '0;
            slice <= '0;
            state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (finish) begin
            bit_count <= sum;
            done      <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            acc   <= sum;
            shift <= shift_nxt;
            slice <= slice + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_ones_seq.sv
// Directed bench for count_ones_seq: three parameter sets,
// expected counts queued at start and checked at done.
module tb_count_ones_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        start_a = 0, mode_a = 0, abort_a = 0;
  logic [15:0] data_a = '0;
  logic        busy_a, done_a;
  logic [4:0]  cnt_a;

  logic        start_b = 0, mode_b = 0, abort_b = 0;
  logic [15:0] data_b = '0;
  logic        busy_b, done_b;
  logic [4:0]  cnt_b;

  logic        start_c = 0, mode_c = 0, abort_c = 0;
  logic [7:0]  data_c = '0;
  logic        busy_c, done_c;
  logic [3:0]  cnt_c;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  count_ones_seq #(
    .DATA_WIDTH(16), .BITS_PER_CYCLE(4),
    .COUNT_WIDTH(5), .EARLY_EXIT(0)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .data(data_a), .mode(mode_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .bit_count(cnt_a)
  );

  count_ones_seq #(
    .DATA_WIDTH(16), .BITS_PER_CYCLE(4),
    .COUNT_WIDTH(5), .EARLY_EXIT(1)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .data(data_b), .mode(mode_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .bit_count(cnt_b)
  );

  count_ones_seq #(
    .DATA_WIDTH(8), .BITS_PER_CYCLE(1),
    .COUNT_WIDTH(4), .EARLY_EXIT(0)
  ) dut_c (
    .clk(clk), .reset(reset), .start(start_c),
    .data(data_c), .mode(mode_c), .abort(abort_c),
    .busy(busy_c), .done(done_c), .bit_count(cnt_c)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int u, input logic s,
                       input logic [15:0] d, input logic m);
    case (u)
      0: begin start_a = s; data_a = d; mode_a = m; end
      1: begin start_b = s; data_b = d; mode_b = m; end
      default: begin start_c = s; data_c = d[7:0]; mode_c = m; end
    endcase
  endtask

  function automatic logic busy_of(input int u);
    case (u)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic done_of(input int u);
    case (u)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic [31:0] cnt_of(input int u);
    case (u)
      0: return 32'(cnt_a);
      1: return 32'(cnt_b);
      default: return 32'(cnt_c);
    endcase
  endfunction

  task automatic run_op(input int u, input logic [15:0] d,
                        input logic m, input int exp_cnt,
                        input int exp_lat, input string tag);
    int k;
    @(negedge clk);
    drive(u, 1'b1, d, m);
    exp_q.push_back(exp_cnt);
    @(negedge clk);
    drive(u, 1'b0, ~d, ~m);
    check({tag, "_busy"}, 32'(busy_of(u)), 1);
    k = 0;
    while (done_of(u) !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, k, exp_lat);
    check({tag, "_cnt"}, cnt_of(u), exp_q.pop_front());
    check({tag, "_idle"}, 32'(busy_of(u)), 0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done_of(u)), 0);
    check({tag, "_hold"}, cnt_of(u), exp_cnt);
  endtask

  initial begin
    int t, last, nd;

    repeat (2) @(negedge clk);
    check("rst_busy_a", 32'(busy_a), 0);
    check("rst_done_a", 32'(done_a), 0);
    check("rst_cnt_a", 32'(cnt_a), 0);
    check("rst_busy_b", 32'(busy_b), 0);
    check("rst_cnt_b", 32'(cnt_b), 0);
    check("rst_busy_c", 32'(busy_c), 0);
    check("rst_cnt_c", 32'(cnt_c), 0);
    reset = 1'b1;

    run_op(0, 16'hF0F1, 1'b0, 9, 4, "a_ones");
    run_op(0, 16'hF0F1, 1'b1, 7, 4, "a_zeros");
    run_op(0, 16'hFFFF, 1'b1, 0, 4, "a_ffff_z");

    run_op(1, 16'h0003, 1'b0, 2, 1, "b_0003");
    run_op(1, 16'h8000, 1'b0, 1, 4, "b_8000");
    run_op(1, 16'h0000, 1'b0, 0, 1, "b_0000");
    run_op(1, 16'hFFF0, 1'b1, 4, 1, "b_zeros_ee");

    run_op(2, 16'h00A5, 1'b0, 4, 8, "c_a5");

    // start held high: back-to-back results every N+1 cycles
    @(negedge clk);
    drive(0, 1'b1, 16'hFFFF, 1'b0);
    repeat (3) exp_q.push_back(16);
    t = 0; last = -1; nd = 0;
    while (nd < 3 && t < 40) begin
      @(negedge clk);
      t++;
      if (done_a === 1'b1) begin
        check("ovl_cnt", 32'(cnt_a), exp_q.pop_front());
        if (last < 0) check("ovl_first", t, 5);
        else check("ovl_period", t - last, 5);
        last = t;
        nd++;
        if (nd == 3) drive(0, 1'b0, 16'h0000, 1'b0);
      end
    end
    check("ovl_ndone", nd, 3);
    @(negedge clk);
    check("ovl_stop", 32'(busy_a), 0);

    // start pulse while busy is dropped
    @(negedge clk);
    drive(0, 1'b1, 16'hFFFF, 1'b0);
    exp_q.push_back(16);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 16'h0000, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000, 1'b0);
    t = 0;
    while (done_a !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("ign_lat", t, 2);
    check("ign_cnt", 32'(cnt_a), exp_q.pop_front());
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_a === 1'b1) nd++;
    end
    check("ign_nodone", nd, 0);

    // abort on the second COUNT cycle
    @(negedge clk);
    drive(0, 1'b1, 16'hF0F1, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("abt_busy", 32'(busy_a), 0);
    check("abt_done", 32'(done_a), 0);
    check("abt_cnt", 32'(cnt_a), 16);
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_a === 1'b1) nd++;
    end
    check("abt_nodone", nd, 0);

    // abort on the completion edge wins
    @(negedge clk);
    drive(0, 1'b1, 16'h000F, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("abtl_done", 32'(done_a), 0);
    check("abtl_busy", 32'(busy_a), 0);
    check("abtl_cnt", 32'(cnt_a), 16);

    // start and abort together in IDLE: start wins
    @(negedge clk);
    drive(1, 1'b1, 16'h0003, 1'b0);
    abort_b = 1'b1;
    exp_q.push_back(2);
    @(negedge clk);
    drive(1, 1'b0, 16'h0000, 1'b0);
    abort_b = 1'b0;
    check("sa_busy", 32'(busy_b), 1);
    @(negedge clk);
    check("sa_done", 32'(done_b), 1);
    check("sa_cnt", 32'(cnt_b), exp_q.pop_front());

    // asynchronous reset between edges mid-operation
    @(negedge clk);
    drive(0, 1'b1, 16'hFFFF, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy_a), 0);
    check("arst_done", 32'(done_a), 0);
    check("arst_cnt", 32'(cnt_a), 0);
    @(negedge clk);
    reset = 1'b1;
    run_op(0, 16'h000F, 1'b0, 4, 4, "a_post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
